packet_arbiter: RTL and testbench

- N-to-1 merge point, the inverse of the header-steered router.
- Round-robin arbitrates among p_ninputs valid/ready sources.
- Prepends the winning source index as a header into the top log2(p_ninputs) bits, so a downstream router can steer replies back to the original port.
- Registers the result in a single-entry output pipeline stage with full-throughput backpressure.

---
 rtl/packet_arbiter_if.sv | 35 +++
 rtl/packet_arbiter.sv | 110 +++++++++++
 tb/tb_packet_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/packet_arbiter_if.sv
// Handshake bundle between N valid/ready sources, the merging arbiter and
// its single downstream consumer. The slave modport is the arbiter's view;
// the master modport is the view of whatever drives the sources and the sink.
interface packet_arbiter_if #(
    parameter int p_nbits   = 32,
    parameter int p_ninputs = 4
);
    localparam int S = $clog2(p_ninputs);
    localparam int W = p_nbits - S;

    logic [p_ninputs-1:0]   valid_in;
    logic [p_ninputs*W-1:0] message_in;
    logic [p_ninputs-1:0]   ready_out;
    logic                   valid_out;
    logic [p_nbits-1:0]     message_out;
    logic                   ready_in;

    modport slave (
        input  valid_in,
        input  message_in,
        input  ready_in,
        output ready_out,
        output valid_out,
        output message_out
    );

    modport master (
        output valid_in,
        output message_in,
        output ready_in,
        input  ready_out,
        input  valid_out,
        input  message_out
    );
endinterface

// File: rtl/packet_arbiter.sv
// N-to-1 round-robin merge. The winning source index is prepended as a
// header in the top S bits so a downstream router can steer replies back.
// One output register stage; capture and drain may happen in the same cycle.
module packet_arbiter #(
    parameter int p_nbits   = 32,
    parameter int p_ninputs = 4
) (
    input  logic                 clk,
    input  logic                 reset,   // asynchronous, active low
    packet_arbiter_if.slave      bus
);
    localparam int S = $clog2(p_ninputs);
    localparam int W = p_nbits - S;

    logic               valid_out_q;
    logic               valid_out_d;
    logic [p_nbits-1:0] message_out_q;
    logic [p_nbits-1:0] message_out_d;
    logic [S-1:0]       ptr_q;
    logic [S-1:0]       ptr_d;

    logic                 load_s;
    logic                 any_valid_s;
    logic [S-1:0]         win_idx_s;
    logic [p_ninputs-1:0] grant_s;
    logic [p_ninputs-1:0] ready_out_s;
    logic [W-1:0]         payload_s;

    // Stage may accept when it is empty or its content leaves this cycle.
    always_comb begin
        load_s = !valid_out_q || bus.ready_in;
    end

    // Round-robin search: first valid source starting at ptr, wrapping.
    always_comb begin
        logic [S-1:0] idx_v;
        idx_v       = '0;
        any_valid_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < p_ninputs; k++) begin
            idx_v = ptr_q + S'(k);
            if (!any_valid_s && bus.valid_in[idx_v]) begin
                any_valid_s = 1'b1;
                win_idx_s   = idx_v;
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    // One-hot grant for the winner, none when nothing is valid.
    always_comb begin
        grant_s = '0;
        if (any_valid_s) begin
            grant_s[win_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Sources only see ready when the stage can load; held low in reset.
    always_comb begin
        ready_out_s = '0;
        if (reset && load_s) begin
            ready_out_s = grant_s;
        end else begin
            ready_out_s = '0;
        end
    end

    // Payload of the winning source.
    always_comb begin
        payload_s = bus.message_in[int'(win_idx_s) * W +: W];
    end

    // Next state of the output stage and the rotation pointer.
    always_comb begin
        valid_out_d   = valid_out_q;
        message_out_d = message_out_q;
        ptr_d         = ptr_q;
        if (load_s) begin
            if (any_valid_s) begin
                valid_out_d   = 1'b1;
                message_out_d = {win_idx_s, payload_s};
                ptr_d         = win_idx_s + S'(1);
            end else begin
                valid_out_d   = 1'b0;
            end
        end else begin
            valid_out_d = valid_out_q;
        end
    end

    // State registers; reset drops any in-flight output immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out_q   <= 1'b0;
            message_out_q <= '0;
            ptr_q         <= '0;
        end else begin
            valid_out_q   <= valid_out_d;
            message_out_q <= message_out_d;
            ptr_q         <= ptr_d;
        end
    end

    assign bus.ready_out   = ready_out_s;
    assign bus.valid_out   = valid_out_q;
    assign bus.message_out = message_out_q;
endmodule

// File: tb/tb_packet_arbiter.sv
// Bench for packet_arbiter (32-bit messages, 4 sources): directed vector
// table, hand-written reset sequence, then random traffic through a
// header-steered router model with per-source scoreboards.
module tb_packet_arbiter;
    localparam int N  = 4;
    localparam int NB = 32;
    localparam int W  = 30;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    packet_arbiter_if #(.p_nbits(NB), .p_ninputs(N)) bus_if ();

    packet_arbiter #(.p_nbits(NB), .p_ninputs(N)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]     vin;
        logic           rdy;
        logic [N*W-1:0] min;
        logic [3:0]     exp_rdy;
        logic           exp_vld;
        logic           chk_msg;
        logic [31:0]    exp_msg;
    } vec_t;

    vec_t vecs [18];

    // reference model state
    logic        m_valid;
    logic [31:0] m_msg;
    int          m_ptr;
    logic [W-1:0] pay [N];
    logic [W-1:0] sb [N][$];
    int sent;
    int received;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int model_winner(input logic [3:0] v, input int p);
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (w < 0 && v[j]) w = j;
        end
        return w;
    endfunction

    task automatic drive_pay();
        bus_if.message_in = {pay[3], pay[2], pay[1], pay[0]};
    endtask

    initial begin
        logic [N*W-1:0] pat_p;
        logic [N*W-1:0] pat_a;
        checks   = 0;
        failures = 0;
        sent     = 0;
        received = 0;
        pat_p = {30'h44, 30'h33, 30'h22, 30'h11};
        pat_a = {30'h0, 30'h0ABCDE, 30'h0, 30'h0};

        //          vin     rdy   min    exp_rdy  vld  chk  exp_msg
        vecs[0]  = '{4'b0000, 1'b1, pat_p, 4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{4'b1111, 1'b1, pat_p, 4'b0001, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{4'b1111, 1'b1, pat_p, 4'b0010, 1'b1, 1'b1, 32'h00000011};
        vecs[3]  = '{4'b1111, 1'b1, pat_p, 4'b0100, 1'b1, 1'b1, 32'h40000022};
        vecs[4]  = '{4'b1111, 1'b1, pat_p, 4'b1000, 1'b1, 1'b1, 32'h80000033};
        vecs[5]  = '{4'b1111, 1'b1, pat_p, 4'b0001, 1'b1, 1'b1, 32'hC0000044};
        vecs[6]  = '{4'b0000, 1'b1, pat_p, 4'b0000, 1'b1, 1'b1, 32'h00000011};
        vecs[7]  = '{4'b0100, 1'b1, pat_a, 4'b0100, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{4'b0000, 1'b1, pat_a, 4'b0000, 1'b1, 1'b1, 32'h800ABCDE};
        vecs[9]  = '{4'b0001, 1'b1, pat_p, 4'b0001, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{4'b1010, 1'b0, pat_p, 4'b0000, 1'b1, 1'b1, 32'h00000011};
        vecs[11] = '{4'b1010, 1'b0, pat_p, 4'b0000, 1'b1, 1'b1, 32'h00000011};
        vecs[12] = '{4'b1010, 1'b0, pat_p, 4'b0000, 1'b1, 1'b1, 32'h00000011};
        vecs[13] = '{4'b1010, 1'b1, pat_p, 4'b0010, 1'b1, 1'b1, 32'h00000011};
        vecs[14] = '{4'b1010, 1'b1, pat_p, 4'b1000, 1'b1, 1'b1, 32'h40000022};
        vecs[15] = '{4'b0101, 1'b1, pat_p, 4'b0001, 1'b1, 1'b1, 32'hC0000044};
        vecs[16] = '{4'b0101, 1'b1, pat_p, 4'b0100, 1'b1, 1'b1, 32'h00000011};
        vecs[17] = '{4'b0000, 1'b1, pat_p, 4'b0000, 1'b1, 1'b1, 32'h80000033};

        // reset state, with all sources requesting
        rst_n = 1'b0;
        bus_if.valid_in   = 4'b1111;
        bus_if.message_in = pat_p;
        bus_if.ready_in   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid_out", 32'(bus_if.valid_out), 32'h0);
        chk("reset_message_out", bus_if.message_out, 32'h0);
        chk("reset_ready_out", 32'(bus_if.ready_out), 32'h0);
        bus_if.valid_in = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // directed vector table
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            bus_if.valid_in   = vecs[r].vin;
            bus_if.ready_in   = vecs[r].rdy;
            bus_if.message_in = vecs[r].min;
            #1;
            chk($sformatf("vec%0d_ready_out", r), 32'(bus_if.ready_out), 32'(vecs[r].exp_rdy));
            chk($sformatf("vec%0d_valid_out", r), 32'(bus_if.valid_out), 32'(vecs[r].exp_vld));
            if (vecs[r].chk_msg) begin
                chk($sformatf("vec%0d_message_out", r), bus_if.message_out, vecs[r].exp_msg);
            end
        end

        // reset while a stalled output is held
        @(negedge clk);
        bus_if.valid_in   = 4'b0001;
        bus_if.ready_in   = 1'b1;
        bus_if.message_in = pat_p;
        @(negedge clk);
        bus_if.valid_in = 4'b1111;
        bus_if.ready_in = 1'b0;
        #1;
        chk("midrst_pre_valid", 32'(bus_if.valid_out), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_async_valid", 32'(bus_if.valid_out), 32'h0);
        chk("midrst_ready_out", 32'(bus_if.ready_out), 32'h0);
        bus_if.ready_in = 1'b1;
        #1;
        chk("midrst_ready_held", 32'(bus_if.ready_out), 32'h0);
        @(negedge clk);
        #1;
        chk("midrst_after_edge_valid", 32'(bus_if.valid_out), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("midrst_first_grant", 32'(bus_if.ready_out), 32'h1);
        @(negedge clk);
        #1;
        chk("midrst_first_valid", 32'(bus_if.valid_out), 32'h1);
        chk("midrst_first_msg", bus_if.message_out, 32'h00000011);

        // clean start for the random phase
        bus_if.valid_in = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0;
        m_msg   = 32'h0;
        m_ptr   = 0;

        // random traffic, model + router scoreboard
        for (int cyc = 0; cyc < 20000 && received < 1000; cyc++) begin
            int w;
            logic ld;
            logic [3:0] exp_r;
            @(negedge clk);
            for (int i = 0; i < N; i++) pay[i] = W'($urandom);
            drive_pay();
            bus_if.valid_in = 4'($urandom);
            bus_if.ready_in = ($urandom_range(0, 3) != 0);
            #1;
            ld = !m_valid || bus_if.ready_in;
            w  = model_winner(bus_if.valid_in, m_ptr);
            exp_r = (ld && w >= 0) ? (4'b0001 << w) : 4'b0000;
            chk("rand_ready_out", 32'(bus_if.ready_out), 32'(exp_r));
            chk("rand_valid_out", 32'(bus_if.valid_out), 32'(m_valid));
            if (m_valid) chk("rand_message_out", bus_if.message_out, m_msg);
            if (bus_if.valid_out && bus_if.ready_in) begin
                int hdr;
                hdr = int'(bus_if.message_out[31:30]);
                received++;
                if (sb[hdr].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL router_port%0d actual=%h required=none", hdr, bus_if.message_out[29:0]);
                end else begin
                    chk($sformatf("router_port%0d", hdr), 32'(bus_if.message_out[29:0]), 32'(sb[hdr].pop_front()));
                end
            end
            @(posedge clk);
            if (ld) begin
                if (w >= 0) begin
                    m_valid = 1'b1;
                    m_msg   = {2'(w), pay[w]};
                    m_ptr   = (w + 1) % N;
                    sb[w].push_back(pay[w]);
                    sent++;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        chk("rand_received_1000", 32'(received >= 1000), 32'h1);

        // drain and confirm no loss or duplication
        @(negedge clk);
        bus_if.valid_in = 4'b0000;
        bus_if.ready_in = 1'b1;
        #1;
        if (bus_if.valid_out) begin
            int hdr;
            hdr = int'(bus_if.message_out[31:30]);
            received++;
            if (sb[hdr].size() != 0) begin
                chk("drain_payload", 32'(bus_if.message_out[29:0]), 32'(sb[hdr].pop_front()));
            end else begin
                checks++;
                failures++;
                $display("FAIL drain_port%0d actual=%h required=none", hdr, bus_if.message_out[29:0]);
            end
        end
        @(negedge clk);
        #1;
        chk("drain_valid_out", 32'(bus_if.valid_out), 32'h0);
        chk("sent_vs_received", 32'(received), 32'(sent));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
